// File: rtl/arm_reg_file_hs_pkg.sv
// Shared types and constants for the ARM register file and its command channel.
package arm_reg_file_hs_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_NUM_REGS = 16;

    localparam logic RF_READ  = 1'b1;
    localparam logic RF_WRITE = 1'b0;

    typedef enum logic [1:0] {
        RF_IDLE = 2'd0,
        RF_EXEC = 2'd1,
        RF_DONE = 2'd2
    } rf_state_e;

endpackage

// File: rtl/arm_reg_file_hs_if.sv
// Command channel and operand read ports of the ARM register file.
interface arm_reg_file_hs_if
    import arm_reg_file_hs_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = 4
);
    logic              cmd_req;
    logic              cmd_ack;
    logic              cmd_rw;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [DATA_W-1:0] cmd_rdata;
    logic              cmd_err;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic [DATA_W-1:0] rdata_a;
    logic [DATA_W-1:0] rdata_b;

    modport master (
        output cmd_req, cmd_rw, cmd_addr, cmd_wdata, raddr_a, raddr_b,
        input  cmd_ack, cmd_rdata, cmd_err, rdata_a, rdata_b
    );

    modport slave (
        input  cmd_req, cmd_rw, cmd_addr, cmd_wdata, raddr_a, raddr_b,
        output cmd_ack, cmd_rdata, cmd_err, rdata_a, rdata_b
    );

endinterface

// File: rtl/arm_reg_file_hs_toggle.sv
// hs_toggle_slave: toggle-handshake acknowledge flop, pending detect and
// sticky protocol-violation flag, shared by handshake-driven blocks.
module hs_toggle_slave (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic accept,
    input  logic busy,
    input  logic complete,
    output logic pending,
    output logic ack,
    output logic err
);
    logic req_lvl_q, req_lvl_d;
    logic ack_q, ack_d;
    logic err_q, err_d;

    assign pending = req ^ ack_q;
    assign ack     = ack_q;
    assign err     = err_q;

    // Any request movement while a command is in flight breaks the protocol.
    always_comb begin
        req_lvl_d = accept ? req : req_lvl_q;
        ack_d     = complete ? req_lvl_q : ack_q;
        err_d     = err_q | (busy & (req != req_lvl_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_lvl_q <= 1'b0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            req_lvl_q <= req_lvl_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

endmodule

// File: rtl/arm_reg_file_hs.sv
// ARM register file: toggle-handshake command channel plus two registered
// operand read ports. Define ARM_RF_BYPASS_EN to forward command writes to them.
module arm_reg_file_hs
    import arm_reg_file_hs_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned NUM_REGS = DEF_NUM_REGS,
    parameter int unsigned ADDR_W   = 4
)(
    input logic               clk,
    input logic               rst,
    arm_reg_file_hs_if.slave  bus
);
    rf_state_e         state_q, state_d;
    logic              rw_q, rw_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] cmd_rdata_q, cmd_rdata_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;
    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic [DATA_W-1:0] mem_d [NUM_REGS];

    logic pending, ack, err;
    logic wr_now;

    hs_toggle_slave u_hs (
        .clk      (clk),
        .rst      (rst),
        .req      (bus.cmd_req),
        .accept   ((state_q == RF_IDLE) && pending),
        .busy     (state_q != RF_IDLE),
        .complete (state_q == RF_DONE),
        .pending  (pending),
        .ack      (ack),
        .err      (err)
    );

    assign wr_now = (state_q == RF_EXEC) && (rw_q == RF_WRITE);

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cmd_rdata_d = cmd_rdata_q;
        mem_d       = mem_q;
        case (state_q)
            RF_IDLE: begin
                if (pending) begin
                    rw_d    = bus.cmd_rw;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    state_d = RF_EXEC;
                end
            end
            RF_EXEC: begin
                if (rw_q == RF_WRITE) mem_d[addr_q] = wdata_q;
                else                  cmd_rdata_d   = mem_q[addr_q];
                state_d = RF_DONE;
            end
            RF_DONE: state_d = RF_IDLE;
            default: state_d = RF_IDLE;
        endcase
    end

    // Operand ports read the pre-write array; bypass forwards the write in flight.
    always_comb begin
        rdata_a_d = mem_q[bus.raddr_a];
        rdata_b_d = mem_q[bus.raddr_b];
`ifdef ARM_RF_BYPASS_EN
        if (wr_now && (addr_q == bus.raddr_a)) rdata_a_d = wdata_q;
        if (wr_now && (addr_q == bus.raddr_b)) rdata_b_d = wdata_q;
`else
        if (wr_now && 1'b0) rdata_a_d = wdata_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RF_IDLE;
            rw_q        <= RF_WRITE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cmd_rdata_q <= '0;
            rdata_a_q   <= '0;
            rdata_b_q   <= '0;
            mem_q       <= '{default: '0};
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cmd_rdata_q <= cmd_rdata_d;
            rdata_a_q   <= rdata_a_d;
            rdata_b_q   <= rdata_b_d;
            mem_q       <= mem_d;
        end
    end

    assign bus.cmd_ack   = ack;
    assign bus.cmd_err   = err;
    assign bus.cmd_rdata = cmd_rdata_q;
    assign bus.rdata_a   = rdata_a_q;
    assign bus.rdata_b   = rdata_b_q;

endmodule
